obi_subordinate: RTL
====================

Name: obi_subordinate

Overview:
OBI v1 subordinate (responder) that terminates A-channel requests from an OBI manager and returns R-channel responses. It contains a flop-based word memory with byte-enable writes, address-range and alignment error checking, and an in-order response FIFO. The FIFO lets it accept back-to-back requests while R-channel backpressure is present. It serves as the bus target for manager-side blocks and as the reference endpoint in their benches.

Parameters:
ADDR_WIDTH, 32, address width; 32 or 64.
DATA_WIDTH, 32, data width; 32 or 64.
NUM_WORDS, 16, memory depth in DATA_WIDTH words; power of two, at least 2.
BASE_ADDR, 0, byte address of word 0; aligned to NUM_WORDS*DATA_WIDTH/8.
RSP_DEPTH, 2, response FIFO depth (maximum outstanding responses); at least 1.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset; synchronous, active-high.
obi_req_i  in  1  A-channel request.
obi_gnt_o  out  1  A-channel grant.
obi_addr_i  in  ADDR_WIDTH  byte address.
obi_we_i  in  1  1 = write, 0 = read.
obi_be_i  in  DATA_WIDTH/8  byte enables.
obi_wdata_i  in  DATA_WIDTH  write data.
obi_rvalid_o  out  1  R-channel valid.
obi_rready_i  in  1  R-channel ready.
obi_rdata_o  out  DATA_WIDTH  read data.
obi_err_o  out  1  response error.
err_cnt_o  out  8  count of errored transactions, saturating.

Behaviour:
- Reset (rst_i high at a rising edge):
  - Memory is cleared to 0; FIFO is emptied; err_cnt_o = 0.
  - Outputs go to obi_gnt_o = 1, obi_rvalid_o = 0, obi_rdata_o = 0, obi_err_o = 0.
  - Reset mid-transaction drops all queued responses. No memory write occurs in a cycle where rst_i is high.
- Grant: obi_gnt_o = (fifo_count < RSP_DEPTH). It is computed from registered count only and never depends on obi_req_i.
- Accept: a transaction is accepted in cycle t when obi_req_i & obi_gnt_o.
- Decode: the address is in range iff BASE_ADDR <= addr < BASE_ADDR + NUM_WORDS*DATA_WIDTH/8. A transaction errors if it is out of range or if the low log2(DATA_WIDTH/8) address bits are nonzero. Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
- Write, no error: each byte lane with be set is updated at the end of cycle t. be = 0 is a legal no-op. The response carries rdata = 0, err = 0.
- Read, no error: response rdata = memory word as of cycle t (the byte enables are ignored), err = 0.
- Errored transaction: memory is untouched; response carries rdata = 0, err = 1; err_cnt_o increments at the end of t and saturates at 0xFF.
- Response timing: the response is pushed into the FIFO at the end of t, so obi_rvalid_o is high at t+1 at the earliest. Minimum latency is 1 cycle. Responses are strictly in order.
- R channel: obi_rvalid_o = FIFO not empty. rdata and err show the FIFO head and are held stable while rvalid is high and rready is low. The head is popped when rvalid & rready.
- Push and pop in the same cycle: allowed; count is unchanged. A push when full cannot happen because gnt is low.
- Throughput: with RSP_DEPTH >= 2 and rready held high, one transaction is accepted per cycle.
- Read-after-write to the same word in consecutive cycles returns the new data. Addresses are not wrapped: out-of-range means error, never aliasing.
- The FIFO pointers wrap modulo RSP_DEPTH. fifo_count has width clog2(RSP_DEPTH+1).

Decomposition:
- Package obi_sbr_pkg holds:
  - rsp_t struct: rdata (DATA_WIDTH bits) and err (1 bit);
  - the ERR_CNT_MAX = 8'hFF constant;
  - a function computing the word offset bits from DATA_WIDTH.
- One sub-module, obi_sbr_rsp_fifo: a synchronous FIFO of rsp_t with push/pop/full/empty/count and RSP_DEPTH depth.
- The memory and decode stay in the top level.

Test Plan:
- Reset, then write addr 0x4 with wdata 0xDEADBEEF and be 4'hF; then read 0x4 -> write response rdata 0, err 0; read response 0xDEADBEEF, err 0.
- Write 0x8 with 0x11223344 and be 4'hF; then write 0x8 with 0xAABBCCDD and be 4'b0101; then read 0x8 -> 0x11BB33DD.
- Read 0x40 (out of range) and read 0x6 (misaligned) -> both return err 1, rdata 0; err_cnt_o = 2; memory unchanged.
- Hold rready low and issue 3 back-to-back reads (RSP_DEPTH = 2) -> gnt drops after 2 accepts; rvalid and rdata stay stable; raise rready -> 3 responses arrive in order and gnt re-asserts.
- Hold rready high with req high for 8 cycles of alternating write/read to the same word -> one accept per cycle; each read returns the value written the cycle before.
- Queue 2 responses, then assert rst_i for one cycle -> rvalid = 0, err_cnt_o = 0, gnt = 1; a subsequent read of 0x4 returns 0.

Source files
------------

// File: rtl/obi_sbr_pkg.sv
// obi_sbr_pkg: response type, constants and decode helper shared by obi_subordinate
package obi_sbr_pkg;
  // Sized for the widest supported data bus; narrower instances leave the top bits at zero.
  localparam int MAX_DW = 64;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
  typedef struct packed {
    logic [MAX_DW-1:0] rdata;
    logic err;
  } rsp_t;
  function automatic int word_off_bits(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/obi_sbr_rsp_fifo.sv
// obi_sbr_rsp_fifo: in-order synchronous response FIFO with wrapping pointers
module obi_sbr_rsp_fifo
  import obi_sbr_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  rsp_t          data_i,
  output rsp_t          data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  rsp_t mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q <= nxt(wptr_q);
      end
      if (pop_i) rptr_q <= nxt(rptr_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign data_o  = mem_q[rptr_q];
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/obi_subordinate.sv
// obi_subordinate: OBI v1 responder with byte-enable word memory, decode errors and queued responses
module obi_subordinate
  import obi_sbr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int RSP_DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  input  logic                    obi_rready_i,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o,
  output logic [7:0]              err_cnt_o
);
  localparam int OFF = word_off_bits(DATA_WIDTH);
  localparam int IW = $clog2(NUM_WORDS);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [7:0] err_cnt_q;
  logic [IW-1:0] idx;
  logic [CW-1:0] rsp_cnt;
  logic err, accept, empty, full;
  rsp_t push_rsp, head;
  logic unused_rsp;
  // BASE_ADDR is aligned to the memory span, so range check is an upper-bit compare.
  assign idx = obi_addr_i[OFF +: IW];
  assign err = (obi_addr_i[ADDR_WIDTH-1:OFF+IW] != BASE_ADDR[ADDR_WIDTH-1:OFF+IW])
             || (obi_addr_i[OFF-1:0] != '0);
  assign obi_gnt_o = rsp_cnt < CW'(RSP_DEPTH);
  assign accept = obi_req_i & obi_gnt_o;
  assign push_rsp = '{rdata: (err || obi_we_i) ? '0 : MAX_DW'(mem_q[idx]), err: err};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      err_cnt_q <= '0;
    end else if (accept) begin
      if (err) err_cnt_q <= err_cnt_q == ERR_CNT_MAX ? err_cnt_q : err_cnt_q + 8'd1;
      else if (obi_we_i)
        for (int b = 0; b < NB; b++)
          if (obi_be_i[b]) mem_q[idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
    end
  end
  obi_sbr_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (accept),
    .pop_i  (obi_rvalid_o & obi_rready_i),
    .data_i (push_rsp),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(rsp_cnt)
  );
  assign obi_rvalid_o = !empty;
  assign obi_rdata_o  = empty ? '0 : head.rdata[DATA_WIDTH-1:0];
  assign obi_err_o    = !empty & head.err;
  assign err_cnt_o    = err_cnt_q;
  assign unused_rsp   = ^{head, full};
endmodule
